// File: rtl/flash_read_arbiter_if.sv
// Read-channel bundle between the two requesters (s0 = fetch, s1 = data/DMA),
// the arbiter, and the flash controller's single AXI-lite read port (m).
interface flash_read_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              s0_axi_arvalid;
  logic              s0_axi_arready;
  logic [ADDR_W-1:0] s0_axi_araddr;
  logic [2:0]        s0_axi_arprot;
  logic              s0_axi_rvalid;
  logic              s0_axi_rready;
  logic [DATA_W-1:0] s0_axi_rdata;

  logic              s1_axi_arvalid;
  logic              s1_axi_arready;
  logic [ADDR_W-1:0] s1_axi_araddr;
  logic [2:0]        s1_axi_arprot;
  logic              s1_axi_rvalid;
  logic              s1_axi_rready;
  logic [DATA_W-1:0] s1_axi_rdata;

  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [ADDR_W-1:0] m_axi_araddr;
  logic [2:0]        m_axi_arprot;
  logic              m_axi_rvalid;
  logic              m_axi_rready;
  logic [DATA_W-1:0] m_axi_rdata;

  // Arbiter's view: target for s0/s1, initiator toward flash.
  modport slave (
    input  s0_axi_arvalid, s0_axi_araddr, s0_axi_arprot, s0_axi_rready,
    output s0_axi_arready, s0_axi_rvalid, s0_axi_rdata,
    input  s1_axi_arvalid, s1_axi_araddr, s1_axi_arprot, s1_axi_rready,
    output s1_axi_arready, s1_axi_rvalid, s1_axi_rdata,
    output m_axi_arvalid, m_axi_araddr, m_axi_arprot, m_axi_rready,
    input  m_axi_arready, m_axi_rvalid, m_axi_rdata
  );

  // Environment's view: requesters plus flash controller.
  modport master (
    output s0_axi_arvalid, s0_axi_araddr, s0_axi_arprot, s0_axi_rready,
    input  s0_axi_arready, s0_axi_rvalid, s0_axi_rdata,
    output s1_axi_arvalid, s1_axi_araddr, s1_axi_arprot, s1_axi_rready,
    input  s1_axi_arready, s1_axi_rvalid, s1_axi_rdata,
    input  m_axi_arvalid, m_axi_araddr, m_axi_arprot, m_axi_rready,
    output m_axi_arready, m_axi_rvalid, m_axi_rdata
  );
endinterface

// File: rtl/flash_read_arbiter.sv
// Two-requester arbiter for the flash controller's single AXI-lite read port.
// One transaction outstanding at a time; round-robin or fixed s0 priority.
module flash_read_arbiter #(
  parameter bit          RR_EN  = 1'b1,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  flash_read_arbiter_if.slave   bus,
  output logic [1:0]            grant,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_grant;
  logic              r_last_grant;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_prot;

  logic              w_s0_win;
  logic              w_s1_win;
  logic              w_accept;
  logic              w_r_hs;

  // Winner selection: s0 takes a tie unless round-robin says s1 is due.
  always_comb begin
    w_s0_win = bus.s0_axi_arvalid &
               (~bus.s1_axi_arvalid | (RR_EN == 1'b0) | r_last_grant);
    w_s1_win = bus.s1_axi_arvalid & ~w_s0_win;
    w_accept = (r_state == ST_IDLE) & (w_s0_win | w_s1_win);
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next state plus all handshake outputs; data path is steered by r_grant.
  always_comb begin
    w_next             = r_state;
    w_r_hs             = 1'b0;
    bus.s0_axi_arready = 1'b0;
    bus.s1_axi_arready = 1'b0;
    bus.s0_axi_rvalid  = 1'b0;
    bus.s1_axi_rvalid  = 1'b0;
    bus.s0_axi_rdata   = '0;
    bus.s1_axi_rdata   = '0;
    bus.m_axi_arvalid  = 1'b0;
    bus.m_axi_rready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.s0_axi_arready = w_s0_win;
        bus.s1_axi_arready = w_s1_win;
        if (w_s0_win | w_s1_win) w_next = ST_ADDR;
      end
      ST_ADDR: begin
        bus.m_axi_arvalid = 1'b1;
        if (bus.m_axi_arready) w_next = ST_DATA;
      end
      ST_DATA: begin
        if (r_grant[0]) begin
          bus.s0_axi_rvalid = bus.m_axi_rvalid;
          bus.s0_axi_rdata  = bus.m_axi_rdata;
          bus.m_axi_rready  = bus.s0_axi_rready;
        end else begin
          bus.s1_axi_rvalid = bus.m_axi_rvalid;
          bus.s1_axi_rdata  = bus.m_axi_rdata;
          bus.m_axi_rready  = bus.s1_axi_rready;
        end
        w_r_hs = bus.m_axi_rvalid & bus.m_axi_rready;
        if (w_r_hs) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Latch the winning request on acceptance; record the owner on completion.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_grant      <= '0;
      r_last_grant <= 1'b1;
      r_addr       <= '0;
      r_prot       <= '0;
    end else if (w_accept) begin
      r_grant <= {w_s1_win, w_s0_win};
      r_addr  <= w_s0_win ? bus.s0_axi_araddr : bus.s1_axi_araddr;
      r_prot  <= w_s0_win ? bus.s0_axi_arprot : bus.s1_axi_arprot;
    end else if (w_r_hs) begin
      r_last_grant <= r_grant[1];
      r_grant      <= '0;
    end
  end

  assign bus.m_axi_araddr = r_addr;
  assign bus.m_axi_arprot = r_prot;
  assign grant            = r_grant;
  assign busy             = (r_state != ST_IDLE);

endmodule
